alu_seq_n: RTL and testbench
============================

ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (legal values 8, 16, 32, 64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift/rotate amount width.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port Clear  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Control  input  5  opcode, team 5-bit ALU encoding (add=00011 ... halt=11011).
REQ-007 SHALL have ports reg_A, reg_B  input  WIDTH  operands.
REQ-008 SHALL have ports Branch, IncrementPC  input  1  branch-taken qualifier and PC-increment override.
REQ-009 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port Done  output  1  one-cycle pulse; reg_C and flags valid.
REQ-011 SHALL have port reg_C  output  2*WIDTH  result; [2W-1:W]=HI, [W-1:0]=LO.
REQ-012 SHALL have port Flags  output  6  {IllegalOp, DivZero, Overflow, Carry, Negative, Zero}.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE; register reg_A, reg_B, Control, Branch and IncrementPC when Start is accepted in IDLE.
REQ-014 SHALL, for single-cycle ops (accepted at edge k), register the result with Done=1 at edge k+1, then return to IDLE.
REQ-015 SHALL, for MUL/DIV, go IDLE->RUN for WIDTH iteration cycles, then FIX (sign correction) for 1 cycle, then DONE; Done registered at edge k+WIDTH+2.
REQ-016 SHALL hold Busy=1 from the edge after acceptance until the edge Done rises; Busy=0 while Done=1; Start is ignored while Busy=1.
REQ-017 SHALL give IncrementPC priority: LO=reg_B+1, HI=0, single-cycle, regardless of Control.
REQ-018 SHALL compute ADD/ADDI/LD/LDI/ST as A+B, SUB as A-B, AND/ANDI, OR/ORI, NOT B, NEG B (0-B), all WIDTH-bit with HI=0.
REQ-019 SHALL use reg_B[SHAMT_W-1:0] as shift/rotate amount for SHL, SHR, SHRA (sign fill), ROL, ROR; amount 0 returns A.
REQ-020 SHALL compute BR as A+B when Branch=1, else pass A.
REQ-021 SHALL compute MUL as signed 2W-bit product via iterative shift-add on magnitudes, negated in FIX when operand signs differ.
REQ-022 SHALL compute DIV as signed restoring division: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
REQ-023 SHALL, on DIV with B=0, skip RUN: LO=all ones, HI=A, DivZero=1, single-cycle latency.
REQ-024 SHALL, on DIV of most-negative by -1, return LO=most-negative, HI=0, Overflow=1.
REQ-025 SHALL set Zero when the full 2W result is 0, Negative=result MSB (bit W-1 for single-width ops, 2W-1 for MUL/DIV).
REQ-026 SHALL set Carry (carry-out / not-borrow) and Overflow (signed) only for ADD-class and SUB; else 0 except REQ-024.
REQ-027 SHALL, for NOP/HALT, hold reg_C unchanged, clear Flags, and still pulse Done.
REQ-028 SHALL, for unknown opcodes, set reg_C=0 and IllegalOp=1 with Done pulse.
REQ-029 SHALL hold reg_C and Flags stable between Done pulses; mid-operation changes on inputs have no effect.

Reset
REQ-030 SHALL, while Clear=0, force state IDLE, Busy=0, Done=0, reg_C=0, Flags=0, iteration counter=0, independent of Clock.
REQ-031 SHALL abandon any in-flight MUL/DIV on Clear=0 with no Done; first Start is accepted on the first posedge after Clear rises.

Structure
REQ-032 SHALL place opcode constants, FSM state encoding and flag bit indices in shared package alu_pkg.
REQ-033 SHALL implement MUL/DIV iteration in one sub-module alu_muldiv_iter (start, mode, magnitudes in; 2W result, done out).

Verification
REQ-034 SHALL cover ADD WIDTH=32 A=FFFFFFFF, B=1 -> Done at k+1, LO=0, Zero=1, Carry=1, Overflow=0.
REQ-035 SHALL cover MUL A=-3, B=7 -> Done at k+34, reg_C=FFFFFFFF_FFFFFFEB, Negative=1, Busy high 33 cycles.
REQ-036 SHALL cover DIV A=-7, B=2 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1); DIV B=0 -> LO=FFFFFFFF, HI=A, DivZero=1 at k+1.
REQ-037 SHALL cover Start pulsed during MUL with ADD opcode -> ignored, MUL result unchanged, single Done.
REQ-038 SHALL cover Clear=0 at RUN cycle 10 of DIV -> Busy=0, reg_C=0 immediately, no Done; subsequent SUB 5-3 -> LO=2 at k+1.
REQ-039 SHALL cover WIDTH=8 ROR A=81, B=1 -> LO=C0; opcode 11111 -> reg_C=0, IllegalOp=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
//   - 5-bit opcode encoding
//   - FSM state encoding
//   - bit positions inside the 6-bit Flags output
package alu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Flags = {IllegalOp, DivZero, Overflow, Carry, Negative, Zero}
  localparam int FLG_ZERO = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_CARRY= 2;
  localparam int FLG_OVF  = 3;
  localparam int FLG_DIVZ = 4;
  localparam int FLG_ILL  = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned iterative multiply (shift-add) / restoring divide.
//   Clock, Clear : clock, async active-low reset
//   i_start      : load magnitudes and begin WIDTH iterations
//   i_div        : 1 = divide, 0 = multiply
//   i_mag_a/b    : unsigned magnitudes (multiplier/multiplicand, dividend/divisor)
//   o_res        : MUL -> 2W product; DIV -> {remainder, quotient}
//   o_done       : high in the cycle whose closing edge performs the last step
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               i_start,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [WIDTH-1:0]   i_mag_b,
  output logic [2*WIDTH-1:0] o_res,
  output logic               o_done
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             r_run, r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_m;

  logic [WIDTH:0]   w_sum, w_rsh, w_diff;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : '0)};
    w_rsh    = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_rsh - {1'b0, r_m};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_div) begin
      // Restoring step: keep the trial subtraction only if it did not borrow.
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rsh[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add-then-shift: carry of the add becomes the new top bit.
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done = r_run && (r_cnt == CNT_W'(WIDTH-1));
  assign o_res  = {r_hi, r_lo};

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_m   <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_div <= i_div;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= i_mag_a;
      r_m   <= i_mag_b;
    end else if (r_run) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= o_done ? '0 : r_cnt + CNT_W'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: sequential ALU, single-cycle logic/arith ops plus iterative MUL/DIV.
//   Clock, Clear       : clock, async active-low reset
//   Start              : request, sampled only in IDLE
//   Control            : 5-bit opcode (alu_pkg)
//   reg_A, reg_B       : operands
//   Branch, IncrementPC: branch-taken qualifier, PC-increment override
//   Busy               : operation in progress (low during the Done cycle)
//   Done               : one-cycle result-valid pulse
//   reg_C              : {HI, LO} result
//   Flags              : {IllegalOp, DivZero, Overflow, Carry, Negative, Zero}
module alu_seq_n #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Start,
  input  logic [4:0]         Control,
  input  logic [WIDTH-1:0]   reg_A,
  input  logic [WIDTH-1:0]   reg_B,
  input  logic               Branch,
  input  logic               IncrementPC,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] reg_C,
  output logic [5:0]         Flags
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [4:0]         r_op;
  logic               r_br, r_inc, r_long;
  logic [2*WIDTH-1:0] r_fix, r_c;
  logic [5:0]         r_flags;
  logic               r_busy, r_done;

  logic               w_accept, w_long_req, w_it_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_it_res, w_fix, w_res, w_rot;
  logic [WIDTH:0]     w_sum;
  logic [5:0]         w_flg;
  logic               w_hold, w_zn, w_wide;
  logic [SHAMT_W-1:0] w_sh;

  // DIV by zero is resolved in one cycle, so only nonzero divisors iterate.
  assign w_long_req = !IncrementPC &&
                      ((Control == OP_MUL) || ((Control == OP_DIV) && (reg_B != '0)));
  assign w_mag_a    = reg_A[WIDTH-1] ? -reg_A : reg_A;
  assign w_mag_b    = reg_B[WIDTH-1] ? -reg_B : reg_B;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .Clock   (Clock),
    .Clear   (Clear),
    .i_start (w_accept && w_long_req),
    .i_div   (Control == OP_DIV),
    .i_mag_a (w_mag_a),
    .i_mag_b (w_mag_b),
    .o_res   (w_it_res),
    .o_done  (w_it_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (Start) begin
        w_accept    = 1'b1;
        w_state_nxt = w_long_req ? S_RUN : S_DONE;
      end
      S_RUN:  if (w_it_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign correction: product negated on sign mismatch; quotient likewise,
  // remainder follows the dividend. MOST_NEG / -1 falls out as MOST_NEG, 0.
  always_comb begin
    w_fix = w_it_res;
    if (r_op == OP_DIV) begin
      w_fix[WIDTH-1:0]       = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_it_res[WIDTH-1:0]
                                                             :  w_it_res[WIDTH-1:0];
      w_fix[2*WIDTH-1:WIDTH] = r_a[WIDTH-1] ? -w_it_res[2*WIDTH-1:WIDTH]
                                            :  w_it_res[2*WIDTH-1:WIDTH];
    end else if (r_a[WIDTH-1] ^ r_b[WIDTH-1]) begin
      w_fix = -w_it_res;
    end
  end

  // Result and flags for the DONE cycle.
  always_comb begin
    w_res  = '0;
    w_flg  = '0;
    w_hold = 1'b0;
    w_zn   = 1'b1;
    w_wide = 1'b0;
    w_sum  = '0;
    w_sh   = r_b[SHAMT_W-1:0];
    w_rot  = '0;
    if (r_inc) begin
      w_res[WIDTH-1:0] = r_b + WIDTH'(1);
    end else if (r_long) begin
      w_res  = r_fix;
      w_wide = 1'b1;
      w_flg[FLG_OVF] = (r_op == OP_DIV) && (r_a == MOST_NEG) && (r_b == '1);
    end else begin
      case (r_op)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: begin
          w_sum            = {1'b0, r_a} + {1'b0, r_b};
          w_res[WIDTH-1:0] = w_sum[WIDTH-1:0];
          w_flg[FLG_CARRY] = w_sum[WIDTH];
          w_flg[FLG_OVF]   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        end
        OP_SUB: begin
          // A + ~B + 1: bit W is the not-borrow carry.
          w_sum            = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);
          w_res[WIDTH-1:0] = w_sum[WIDTH-1:0];
          w_flg[FLG_CARRY] = w_sum[WIDTH];
          w_flg[FLG_OVF]   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        end
        OP_AND, OP_ANDI: w_res[WIDTH-1:0] = r_a & r_b;
        OP_OR,  OP_ORI:  w_res[WIDTH-1:0] = r_a | r_b;
        OP_NOT:          w_res[WIDTH-1:0] = ~r_b;
        OP_NEG:          w_res[WIDTH-1:0] = '0 - r_b;
        OP_SHL:          w_res[WIDTH-1:0] = r_a << w_sh;
        OP_SHR:          w_res[WIDTH-1:0] = r_a >> w_sh;
        OP_SHRA:         w_res[WIDTH-1:0] = $signed(r_a) >>> w_sh;
        OP_ROL: begin
          w_rot            = {r_a, r_a} << w_sh;
          w_res[WIDTH-1:0] = w_rot[2*WIDTH-1:WIDTH];
        end
        OP_ROR: begin
          w_rot            = {r_a, r_a} >> w_sh;
          w_res[WIDTH-1:0] = w_rot[WIDTH-1:0];
        end
        OP_BR:           w_res[WIDTH-1:0] = r_br ? (r_a + r_b) : r_a;
        OP_DIV: begin
          // Only reached with a zero divisor.
          w_res           = {r_a, {WIDTH{1'b1}}};
          w_wide          = 1'b1;
          w_flg[FLG_DIVZ] = 1'b1;
        end
        OP_NOP, OP_HALT: begin
          w_hold = 1'b1;
          w_zn   = 1'b0;
        end
        default: begin
          // Illegal ops report only IllegalOp, not Zero.
          w_flg[FLG_ILL] = 1'b1;
          w_zn           = 1'b0;
        end
      endcase
    end
    if (w_zn) begin
      w_flg[FLG_ZERO] = (w_res == '0);
      w_flg[FLG_NEG]  = w_wide ? w_res[2*WIDTH-1] : w_res[WIDTH-1];
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_br    <= 1'b0;
      r_inc   <= 1'b0;
      r_long  <= 1'b0;
      r_fix   <= '0;
      r_c     <= '0;
      r_flags <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Busy covers the cycles strictly between acceptance and Done.
      r_busy  <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_a    <= reg_A;
        r_b    <= reg_B;
        r_op   <= Control;
        r_br   <= Branch;
        r_inc  <= IncrementPC;
        r_long <= w_long_req;
      end
      if (r_state == S_FIX) r_fix <= w_fix;
      if (r_state == S_DONE) begin
        if (!w_hold) r_c <= w_res;
        r_flags <= w_flg;
      end
    end
  end

  assign Busy  = r_busy;
  assign Done  = r_done;
  assign reg_C = r_c;
  assign Flags = r_flags;

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed bench for alu_seq_n at WIDTH=32 and WIDTH=8.
// Expected results go onto a scoreboard queue when an op is driven and are
// popped and compared when the DUT raises Done.
module tb_alu_seq_n;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101,
                         ROR = 5'b00111, ROL = 5'b01000, SHR = 5'b01001,
                         SHRA = 5'b01010, SHL = 5'b01011, ORI = 5'b01110,
                         DIV = 5'b01111, MUL = 5'b10000, NEG = 5'b10001,
                         NOT_ = 5'b10010, BR = 5'b10011, NOP = 5'b11010,
                         HALT = 5'b11011, ILL = 5'b11111, JR = 5'b10100;

  logic        Clock, Clear;
  logic [4:0]  ctl;
  logic        brn, incpc, st32, st8, sel8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, busy8, done8;
  logic [63:0] c32;
  logic [15:0] c8;
  logic [5:0]  f32, f8;

  logic [63:0] c_obs;
  logic [5:0]  f_obs;
  logic        busy_obs, done_obs;

  typedef struct {
    string       tag;
    logic [63:0] c;
    logic [5:0]  f;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int nassert = 0;
  int nfail   = 0;

  alu_seq_n #(.WIDTH(32)) u32 (
    .Clock(Clock), .Clear(Clear), .Start(st32), .Control(ctl),
    .reg_A(a32), .reg_B(b32), .Branch(brn), .IncrementPC(incpc),
    .Busy(busy32), .Done(done32), .reg_C(c32), .Flags(f32)
  );

  alu_seq_n #(.WIDTH(8)) u8 (
    .Clock(Clock), .Clear(Clear), .Start(st8), .Control(ctl),
    .reg_A(a8), .reg_B(b8), .Branch(brn), .IncrementPC(incpc),
    .Busy(busy8), .Done(done8), .reg_C(c8), .Flags(f8)
  );

  always_comb begin
    c_obs    = sel8 ? {48'b0, c8} : c32;
    f_obs    = sel8 ? f8 : f32;
    busy_obs = sel8 ? busy8 : busy32;
    done_obs = sel8 ? done8 : done32;
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nassert++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one op, push its expectation, wait (bounded) for Done, then compare.
  // inj>0 pulses Start with an ADD and fresh operands at that cycle mid-op.
  task automatic run_op(input string tag, input logic s8, input logic [4:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic br, input logic inc,
                        input logic [63:0] ec, input logic [5:0] ef,
                        input int elat, input int inj);
    exp_t e;
    int   lat, bsy, extra;
    @(negedge Clock);
    sel8 = s8; Clear = 1'b1; ctl = op; brn = br; incpc = inc;
    if (s8) begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
    else    begin a32 = a[31:0]; b32 = b[31:0]; st32 = 1'b1; end
    sb.push_back('{tag, ec, ef, elat});
    @(negedge Clock);
    st8 = 1'b0; st32 = 1'b0;
    lat = 0; bsy = 0;
    do begin
      @(negedge Clock);
      lat++;
      st8 = 1'b0; st32 = 1'b0;
      if (busy_obs) bsy++;
      if (lat == inj) begin
        ctl = ADD; a32 = 32'd1; b32 = 32'd2; a8 = 8'd1; b8 = 8'd2;
        st32 = !sel8; st8 = sel8;
      end
    end while (!done_obs && lat < 100);
    st8 = 1'b0; st32 = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".latency"}, 64'(lat), 64'(e.lat));
    chk({e.tag, ".reg_C"}, c_obs, e.c);
    chk({e.tag, ".Flags"}, 64'(f_obs), 64'(e.f));
    chk({e.tag, ".busy_cycles"}, 64'(bsy), 64'(e.lat > 1 ? e.lat - 1 : 0));
    extra = 0;
    repeat (3) begin
      @(negedge Clock);
      if (done_obs) extra++;
    end
    chk({e.tag, ".done_single"}, 64'(extra), 64'd0);
  endtask

  initial begin
    Clear = 1'b1; ctl = '0; brn = 1'b0; incpc = 1'b0; st32 = 1'b0; st8 = 1'b0;
    sel8 = 1'b0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    #2 Clear = 1'b0;
    #1;
    chk("reset.busy32", 64'(busy32), 64'd0);
    chk("reset.done32", 64'(done32), 64'd0);
    chk("reset.c32", c32, 64'd0);
    chk("reset.f32", 64'(f32), 64'd0);
    chk("reset.c8", 64'(c8), 64'd0);
    repeat (2) @(negedge Clock);
    chk("reset_held.done32", 64'(done32), 64'd0);

    // tag, s8, op, A, B, Branch, IncPC, exp reg_C, exp Flags {I,DZ,V,C,N,Z}, latency, inj
    run_op("add_wrap",   0, ADD,  64'hFFFFFFFF, 64'h1, 0, 0, 64'h0,        6'b000101, 1, 0);
    run_op("add_ovf",    0, ADD,  64'h7FFFFFFF, 64'h1, 0, 0, 64'h80000000, 6'b001010, 1, 0);
    run_op("sub_pos",    0, SUB,  64'd5, 64'd3,         0, 0, 64'd2,        6'b000100, 1, 0);
    run_op("sub_neg",    0, SUB,  64'd3, 64'd5,         0, 0, 64'hFFFFFFFE, 6'b000010, 1, 0);
    run_op("and",        0, AND_, 64'hF0F0F0F0, 64'hFF00FF00, 0, 0, 64'hF000F000, 6'b000010, 1, 0);
    run_op("ori",        0, ORI,  64'h0F, 64'hF0,       0, 0, 64'hFF,       6'b000000, 1, 0);
    run_op("not",        0, NOT_, 64'h55, 64'h0,        0, 0, 64'hFFFFFFFF, 6'b000010, 1, 0);
    run_op("neg",        0, NEG,  64'h0, 64'd5,         0, 0, 64'hFFFFFFFB, 6'b000010, 1, 0);
    run_op("shra",       0, SHRA, 64'h80000000, 64'd4,  0, 0, 64'hF8000000, 6'b000010, 1, 0);
    run_op("shr",        0, SHR,  64'h80000000, 64'd4,  0, 0, 64'h08000000, 6'b000000, 1, 0);
    run_op("shl_amt0",   0, SHL,  64'h12345678, 64'h20, 0, 0, 64'h12345678, 6'b000000, 1, 0);
    run_op("shl31",      0, SHL,  64'h1, 64'd31,        0, 0, 64'h80000000, 6'b000010, 1, 0);
    run_op("rol",        0, ROL,  64'h80000001, 64'd1,  0, 0, 64'h3,        6'b000000, 1, 0);
    run_op("br_taken",   0, BR,   64'h100, 64'h8,       1, 0, 64'h108,      6'b000000, 1, 0);
    run_op("br_not",     0, BR,   64'h100, 64'h8,       0, 0, 64'h100,      6'b000000, 1, 0);
    run_op("incpc",      0, SUB,  64'd9, 64'hFFFFFFFF,  0, 1, 64'h0,        6'b000001, 1, 0);
    run_op("mul_neg",    0, MUL,  64'hFFFFFFFD, 64'd7,  0, 0, 64'hFFFFFFFF_FFFFFFEB, 6'b000010, 34, 0);
    run_op("mul_inject", 0, MUL,  64'hFFFFFFFC, 64'hFFFFFFFB, 0, 0, 64'd20, 6'b000000, 34, 5);
    run_op("div_neg",    0, DIV,  64'hFFFFFFF9, 64'd2,  0, 0, 64'hFFFFFFFF_FFFFFFFD, 6'b000010, 34, 0);
    run_op("div_pos",    0, DIV,  64'd100, 64'd7,       0, 0, 64'h00000002_0000000E, 6'b000000, 34, 0);
    run_op("div_zero",   0, DIV,  64'h1234, 64'd0,      0, 0, 64'h00001234_FFFFFFFF, 6'b010000, 1, 0);
    run_op("div_ovf",    0, DIV,  64'h80000000, 64'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 6'b001000, 34, 0);
    run_op("nop_hold",   0, NOP,  64'h1, 64'h1,         0, 0, 64'h00000000_80000000, 6'b000000, 1, 0);
    run_op("halt_hold",  0, HALT, 64'h2, 64'h2,         0, 0, 64'h00000000_80000000, 6'b000000, 1, 0);
    run_op("illegal",    0, ILL,  64'h5, 64'h5,         0, 0, 64'h0,        6'b100000, 1, 0);
    run_op("illegal_jr", 0, JR,   64'h5, 64'h5,         0, 0, 64'h0,        6'b100000, 1, 0);
    run_op("mul_pre_clr",0, MUL,  64'd6, 64'd7,         0, 0, 64'd42,       6'b000000, 34, 0);

    // Abort a DIV ten cycles into RUN.
    @(negedge Clock);
    sel8 = 1'b0; ctl = DIV; a32 = 32'd1000; b32 = 32'd7; st32 = 1'b1;
    @(negedge Clock);
    st32 = 1'b0;
    repeat (10) @(negedge Clock);
    chk("abort.busy_before", 64'(busy32), 64'd1);
    Clear = 1'b0;
    #1;
    chk("abort.busy", 64'(busy32), 64'd0);
    chk("abort.done", 64'(done32), 64'd0);
    chk("abort.reg_C", c32, 64'd0);
    chk("abort.flags", 64'(f32), 64'd0);
    repeat (3) @(negedge Clock);
    chk("abort.done_held", 64'(done32), 64'd0);
    run_op("sub_after_clr", 0, SUB, 64'd5, 64'd3, 0, 0, 64'd2, 6'b000100, 1, 0);

    // WIDTH = 8 instance
    run_op("w8_ror",     1, ROR,  64'h81, 64'h1, 0, 0, 64'hC0,   6'b000010, 1, 0);
    run_op("w8_illegal", 1, ILL,  64'h81, 64'h1, 0, 0, 64'h0,    6'b100000, 1, 0);
    run_op("w8_add",     1, ADD,  64'hFF, 64'h1, 0, 0, 64'h0,    6'b000101, 1, 0);
    run_op("w8_mul",     1, MUL,  64'hFD, 64'h7, 0, 0, 64'hFFEB, 6'b000010, 10, 0);
    run_op("w8_div",     1, DIV,  64'hF9, 64'h2, 0, 0, 64'hFFFD, 6'b000010, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
